pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL take parameter CTRL_W, default 13, width of the packed control bundle (aluOp 3, memRead, memWrite, aluSrc, writeBackControl 2, regWrt, branchZero, branchNeg, jump, jumpMem).
REQ-002 SHALL take parameter DATA_W, default 32, width of one data channel.
REQ-003 SHALL take parameter NUM_CH, default 4, data channel count; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  upstream (decode) entry present.
REQ-008 in_ready  out  1  stage can accept; registered.
REQ-009 in_ctrl  in  CTRL_W  control bundle from decode.
REQ-010 in_data  in  NUM_CH*DATA_W  packed data channels (pc_plus_y, xrs, xrt, y by default).
REQ-011 flush  in  1  kill all held entries (taken branch/jump).
REQ-012 out_valid  out  1  head entry valid toward execute.
REQ-013 out_ready  in  1  execute accepts head; low = stall.
REQ-014 out_ctrl  out  CTRL_W  head control; all-zero whenever out_valid=0.
REQ-015 out_data  out  NUM_CH*DATA_W  head data.
REQ-016 occupancy  out  2  entries held, 0..2.

Function
REQ-017 SHALL hold two entries: main register (drives outputs) and skid register; state EMPTY, ONE, TWO.
REQ-018 SHALL transfer in when in_valid & in_ready, out when out_valid & out_ready, both evaluated at the same edge.
REQ-019 EMPTY: in-transfer -> ONE, entry loaded into main.
REQ-020 ONE: in only -> TWO (entry to skid); out only -> EMPTY; both -> ONE with main reloaded from input; neither -> hold.
REQ-021 TWO: out-transfer -> ONE with skid moved into main; else hold; no input accepted.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, derived from registered state only (no combinational path from out_ready).
REQ-023 Latency SHALL be one cycle: entry accepted at edge N is on outputs after edge N when stage was EMPTY, or ONE with simultaneous out-transfer.
REQ-024 Order SHALL be preserved; no entry duplicated or dropped except by flush.
REQ-025 flush SHALL have priority: next state EMPTY, any in-transfer in that cycle discarded, out-transfer in that cycle counts as completed.
REQ-026 out_valid=0 SHALL force out_ctrl to zero so a bubble writes no register or memory.
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-028 reset SHALL take precedence over flush and all transfers.
REQ-029 After reset: state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_data=0, skid cleared.
REQ-030 reset asserted mid-operation SHALL discard both entries at that edge.

Configuration
REQ-031 Macro PIPE_STAGE_STATS_EN defined: SHALL add outputs stall_cnt, bubble_cnt, flush_cnt (32 bits each, reset 0, wrap at 2^32): stall = out_valid & ~out_ready, bubble = out_valid=0 while not in reset, flush = flush asserted.
REQ-032 Macro undefined: SHALL omit those ports and counters; all other behaviour identical.

Structure
REQ-033 Package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and control-bundle bit-position constants (ALUOP_LSB, MEMREAD_BIT, ..., JUMPMEM_BIT).
REQ-034 SHALL instantiate sub-module pipe_entry twice (main, skid): a CTRL_W+NUM_CH*DATA_W register with load and clear.

Verification
REQ-035 Reset, then in_valid=1, in_ctrl=0x1ABC, ch0=0x100, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x1ABC, out_data ch0=0x100, occupancy=1.
REQ-036 Stream A,B,C with out_ready=0 -> A in main, B in skid, in_ready=0, C held upstream; raise out_ready -> A,B,C out in order, one per cycle.
REQ-037 occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1, input not captured.
REQ-038 out_ready=1 continuous, in_valid=1 continuous with 10 entries -> 10 outputs on 10 consecutive cycles, occupancy stays 1.
REQ-039 reset during occupancy=2 -> next cycle all outputs at reset values; with PIPE_STAGE_STATS_EN, 3 stall cycles then 1 flush -> stall_cnt=3, flush_cnt=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and control-bundle bit positions for the decode-to-execute pipeline stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_e;

   // Control bundle layout, LSB first
   localparam int ALUOP_LSB      = 0;
   localparam int ALUOP_W        = 3;
   localparam int MEMREAD_BIT    = 3;
   localparam int MEMWRITE_BIT   = 4;
   localparam int ALUSRC_BIT     = 5;
   localparam int WB_LSB         = 6;
   localparam int WB_W           = 2;
   localparam int REGWRT_BIT     = 8;
   localparam int BRANCHZERO_BIT = 9;
   localparam int BRANCHNEG_BIT  = 10;
   localparam int JUMP_BIT       = 11;
   localparam int JUMPMEM_BIT    = 12;
   localparam int CTRL_BITS      = 13;

   function automatic logic [1:0] occupancy_of(input stage_state_e s);
      case (s)
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One pipeline entry register (control + data) with load and clear; clear wins over load.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int W = CTRL_BITS + 128
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= d;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered decode/execute pipeline register with flush.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 13,
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CTRL_W-1:0]        in_ctrl,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [1:0]               occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]              stall_cnt,
   output logic [31:0]              bubble_cnt,
   output logic [31:0]              flush_cnt
`endif
);

   localparam int DW_ALL = NUM_CH * DATA_W;
   localparam int BW     = CTRL_W + DW_ALL;

   stage_state_e  state_reg, state_next;
   logic          in_xfer, out_xfer;
   logic          main_load, main_clear, skid_load, skid_clear;
   logic [BW-1:0] main_d, main_q, skid_q;

   // Handshake depends on registered state only, so in_ready never sees out_ready
   assign in_ready  = (state_reg != TWO);
   assign out_valid = (state_reg != EMPTY);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      state_next = state_reg;
      main_load  = 1'b0;
      main_clear = flush;
      skid_load  = 1'b0;
      skid_clear = flush;
      main_d     = {in_ctrl, in_data};
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_xfer) begin
                  state_next = ONE;
                  main_load  = 1'b1;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_load = 1'b1;
               end else if (in_xfer) begin
                  state_next = TWO;
                  skid_load  = 1'b1;
               end else if (out_xfer) begin
                  state_next = EMPTY;
                  main_clear = 1'b1;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  state_next = ONE;
                  main_load  = 1'b1;
                  main_d     = skid_q;
                  skid_clear = 1'b1;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   pipe_entry #(.W(BW)) u_main (
      .clock (clock),
      .reset (reset),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_entry #(.W(BW)) u_skid (
      .clock (clock),
      .reset (reset),
      .load  (skid_load),
      .clear (skid_clear),
      .d     ({in_ctrl, in_data}),
      .q     (skid_q)
   );

   // A bubble must never carry live control bits into execute
   assign out_ctrl  = out_valid ? main_q[BW-1 -: CTRL_W] : '0;
   assign occupancy = occupancy_of(state_reg);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign out_data[gi*DATA_W +: DATA_W] = main_q[gi*DATA_W +: DATA_W];
      end
   endgenerate

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cnt_reg, bubble_cnt_reg, flush_cnt_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_reg  <= '0;
         bubble_cnt_reg <= '0;
         flush_cnt_reg  <= '0;
      end else begin
         if (out_valid && !out_ready) stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (!out_valid)              bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
         if (flush)                   flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt  = stall_cnt_reg;
   assign bubble_cnt = bubble_cnt_reg;
   assign flush_cnt  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg; statistics checks follow PIPE_STAGE_STATS_EN.
module tb_pipe_stage_reg;

   localparam int CW = 13;
   localparam int DW = 32;
   localparam int NC = 4;
   localparam int BW = CW + NC * DW;

   logic              clock;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [CW-1:0]     in_ctrl;
   logic [NC*DW-1:0]  in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     out_ctrl;
   logic [NC*DW-1:0]  out_data;
   logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0]       stall_cnt, bubble_cnt, flush_cnt;
   logic [31:0]       m_stall, m_bubble, m_flush;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   logic [BW-1:0] sb_q[$];

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NUM_CH(NC)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NC*DW-1:0] mk(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   // Drive one cycle: check outputs against the model, then advance model and DUT by one edge
   task automatic cycle(input logic iv, input logic [CW-1:0] c, input logic [NC*DW-1:0] d,
                        input logic ordy, input logic fl, input logic rs);
      int sz;
      logic [BW-1:0] head;
      logic in_x, out_x;
      in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; reset = rs;
      sz = sb_q.size();
      check("occupancy", BW'(occupancy), BW'(sz));
      check("in_ready", BW'(in_ready), BW'(sz < 2));
      check("out_valid", BW'(out_valid), BW'(sz > 0));
      if (sz > 0) begin
         head = sb_q[0];
         check("out_ctrl", BW'(out_ctrl), BW'(head[BW-1 -: CW]));
         check("out_data", BW'(out_data), BW'(head[NC*DW-1:0]));
      end else begin
         check("out_ctrl_bubble", BW'(out_ctrl), '0);
      end
`ifdef PIPE_STAGE_STATS_EN
      check("stall_cnt", BW'(stall_cnt), BW'(m_stall));
      check("bubble_cnt", BW'(bubble_cnt), BW'(m_bubble));
      check("flush_cnt", BW'(flush_cnt), BW'(m_flush));
      if (rs) begin
         m_stall = 0; m_bubble = 0; m_flush = 0;
      end else begin
         if (sz > 0 && !ordy) m_stall++;
         if (sz == 0) m_bubble++;
         if (fl) m_flush++;
      end
`endif
      in_x  = iv && (sz < 2);
      out_x = (sz > 0) && ordy;
      if (rs || fl) begin
         sb_q.delete();
      end else begin
         if (out_x) void'(sb_q.pop_front());
         if (in_x) sb_q.push_back({c, d});
      end
      $display("cycle t=%0t iv=%0b ordy=%0b fl=%0b rs=%0b occ_before=%0d ctrl_in=%0h",
               $time, iv, ordy, fl, rs, sz, c);
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
      m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
      repeat (2) @(posedge clock);
      #1;
      check("reset_out_data", BW'(out_data), '0);

      // Single entry, one-cycle latency
      cycle(1'b1, 13'h1ABC, 128'h100, 1'b1, 1'b0, 1'b0);
      check("lat_out_data_ch0", BW'(out_data[31:0]), BW'(32'h100));
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // A, B fill the stage; C waits upstream until space opens
      cycle(1'b1, 13'h0A1, mk(32'hA000), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 13'h0B2, mk(32'hB000), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 13'h0C3, mk(32'hC000), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 13'h0C3, mk(32'hC000), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 13'h0C3, mk(32'hC000), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Flush while full with a competing input
      cycle(1'b1, 13'h011, mk(32'h1100), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 13'h022, mk(32'h2200), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 13'h033, mk(32'h3300), 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Ten back-to-back entries at full throughput
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, CW'(13'h100 + i), mk(32'h5000 + 32'(i) * 16), 1'b1, 1'b0, 1'b0);
      end
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Statistics: reset, load, three stalls, one flush
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 13'h077, mk(32'h7700), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
      check("stats_stall_eq3", BW'(stall_cnt), BW'(32'd3));
      check("stats_flush_eq1", BW'(flush_cnt), BW'(32'd1));
`endif

      // Reset while holding two entries
      cycle(1'b1, 13'h0D1, mk(32'hD100), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 13'h0D2, mk(32'hD200), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 13'h0D3, mk(32'hD300), 1'b1, 1'b0, 1'b1);
      check("midrst_out_data", BW'(out_data), '0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Random handshakes with occasional flush
      for (int i = 0; i < 60; i++) begin
         cycle(1'($urandom_range(0, 1)), CW'($urandom), mk($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 15) == 0), 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
